lsu_dmem: RTL and testbench

LSU_DMEM -- requirements
Module: lsu_dmem

---
 rtl/lsu_dmem.sv | 143 ++++++++++++++
 tb/tb_lsu_dmem.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem.sv
// Load/store unit data-memory port: one RV32 load or store per request.
// Three-state sequencer (IDLE, ACCESS, RESP) with size/sign handling and error detection.
module lsu_dmem #(
  parameter bit MISALIGN_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        valid,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic        dmem_wen,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_n;
  logic        wen_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        mis;
  logic        illegal;
  logic        err;
  logic [1:0]  off;
  logic [31:0] sh;
  logic [31:0] load;

  always_comb begin
    mis     = 1'b0;
    illegal = 1'b0;
    case (f3_q)
      3'b000: ;
      3'b001: mis = addr_q[0];
      3'b010: mis = (addr_q[1:0] != 2'b00);
      3'b100: illegal = wen_q;
      3'b101: begin
        mis     = addr_q[0];
        illegal = wen_q;
      end
      default: illegal = 1'b1;
    endcase
    err = illegal | (mis & MISALIGN_ERR);
  end

  // Without error reporting, misaligned halves/words snap down to alignment.
  always_comb begin
    off = addr_q[1:0];
    if (!MISALIGN_ERR) begin
      if (f3_q[1:0] == 2'b01) off[0] = 1'b0;
      if (f3_q[1:0] == 2'b10) off    = 2'b00;
    end
  end

  assign req_ready  = (state == IDLE) & ~rst;
  assign valid      = (state == ACCESS) & ~err & ~rst;
  assign dmem_addr  = valid ? {addr_q[31:2], 2'b00} : 32'h0;
  assign dmem_wen   = valid & wen_q;
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    dmem_wmask = 4'b0000;
    dmem_wdata = 32'h0;
    if (valid) begin
      case (f3_q[1:0])
        2'b00: begin
          dmem_wmask = 4'b0001 << off;
          dmem_wdata = {4{wdata_q[7:0]}};
        end
        2'b01: begin
          dmem_wmask = 4'b0011 << off;
          dmem_wdata = {2{wdata_q[15:0]}};
        end
        default: begin
          dmem_wmask = 4'b1111;
          dmem_wdata = wdata_q;
        end
      endcase
    end
  end

  assign sh = dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load = {24'h0, sh[7:0]};
      3'b101:  load = {16'h0, sh[15:0]};
      default: load = dmem_rdata;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (req_valid) state_n = ACCESS;
      ACCESS:  state_n = RESP;
      RESP:    if (resp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ACCESS) begin
        err_q   <= err;
        rdata_q <= (err | wen_q) ? 32'h0 : load;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_valid & req_ready) begin
      wen_q   <= req_wen;
      f3_q    <= req_funct3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_lsu_dmem.sv
// Randomized bench for lsu_dmem against a byte-array memory model.
// A second instance with alignment snapping covers the non-error mode.
module tb_lsu_dmem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_wen, resp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err, valid, dmem_wen;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;

  logic        b_req_ready, b_resp_valid, b_resp_err, b_valid, b_dmem_wen;
  logic [31:0] b_resp_rdata, b_dmem_addr, b_dmem_wdata;
  logic [31:0] b_dmem_rdata = 32'hCAFEF00D;
  logic [3:0]  b_dmem_wmask;

  lsu_dmem #(.MISALIGN_ERR(1'b1)) u0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .valid(valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_wen(dmem_wen), .dmem_wmask(dmem_wmask), .dmem_rdata(dmem_rdata)
  );

  lsu_dmem #(.MISALIGN_ERR(1'b0)) u1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .valid(b_valid), .dmem_addr(b_dmem_addr), .dmem_wdata(b_dmem_wdata),
    .dmem_wen(b_dmem_wen), .dmem_wmask(b_dmem_wmask),
    .dmem_rdata(b_dmem_rdata)
  );

  // RAM seen by u0: 256 bytes mirrored across the address space.
  logic [31:0] ram [64];
  assign dmem_rdata = ram[dmem_addr[7:2]];

  always @(posedge clk) begin
    if (valid && dmem_wen)
      for (int i = 0; i < 4; i++)
        if (dmem_wmask[i])
          ram[dmem_addr[7:2]][8*i +: 8] <= dmem_wdata[8*i +: 8];
  end

  logic [7:0] mdl [256];
  int tests = 0;
  int fails = 0;

  logic        o_valid, o_wen, o_rvalid, o_err, q_valid, q_err;
  logic [3:0]  o_mask;
  logic [31:0] o_addr, o_wdata, o_data, q_addr, q_data;

  function automatic bit m_err(logic w, logic [2:0] f, logic [31:0] a);
    if (f == 3'd3 || f == 3'd6 || f == 3'd7) return 1'b1;
    if (w && f[2]) return 1'b1;
    if (f[1:0] == 2'b01 && a[0]) return 1'b1;
    if (f[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a);
    int n = 1 << f[1:0];
    int b = int'(a[7:0]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v |= 32'(mdl[(b + i) % 256]) << (8 * i);
    if (!f[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
    if (!f[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  function automatic logic [3:0] m_mask(logic [2:0] f, logic [31:0] a);
    int n = 1 << f[1:0];
    logic [3:0] m = 4'h0;
    for (int i = 0; i < n; i++) m[int'(a[1:0]) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(logic [2:0] f, logic [31:0] d);
    case (f[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  task automatic m_store(logic [2:0] f, logic [31:0] a, logic [31:0] d);
    int n = 1 << f[1:0];
    for (int i = 0; i < n; i++) mdl[(int'(a[7:0]) + i) % 256] = d[8*i +: 8];
  endtask

  task automatic run_op(input logic w, input logic [2:0] f,
                        input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_wen = w; req_funct3 = f;
    req_addr = a; req_wdata = d; resp_ready = 1'b1;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL handshake_timeout: req_ready stayed 0");
    end
    @(negedge clk);
    req_valid = 1'b0;
    o_valid = valid; o_wen = dmem_wen; o_mask = dmem_wmask;
    o_addr = dmem_addr; o_wdata = dmem_wdata;
    q_valid = b_valid; q_addr = b_dmem_addr;
    @(negedge clk);
    o_rvalid = resp_valid; o_data = resp_rdata; o_err = resp_err;
    q_data = b_resp_rdata; q_err = b_resp_err;
    if (w && !m_err(w, f, a)) m_store(f, a, d);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_wen = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({req_ready, valid, dmem_wen, dmem_wmask, dmem_addr} !== 39'h0) begin
      fails++;
      $display("FAIL reset_dmem: got rdy=%b v=%b wen=%b m=%h a=%h want all 0",
               req_ready, valid, dmem_wen, dmem_wmask, dmem_addr);
    end
    tests++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'h0) begin
      fails++;
      $display("FAIL reset_resp: got v=%b e=%b d=%h want 0",
               resp_valid, resp_err, resp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed();
    run_op(1'b1, 3'd2, 32'h80000010, 32'hDEADBEEF);
    tests++;
    if ({o_valid, o_wen, o_mask, o_addr, o_wdata} !==
        {1'b1, 1'b1, 4'hF, 32'h80000010, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL sw: got v=%b wen=%b m=%h a=%h d=%h want 1 1 f 80000010 deadbeef",
               o_valid, o_wen, o_mask, o_addr, o_wdata);
    end
    run_op(1'b0, 3'd2, 32'h80000010, 32'h0);
    tests++;
    if ({o_rvalid, o_err, o_data} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL lw: got v=%b e=%b d=%h want 1 0 deadbeef", o_rvalid, o_err, o_data);
    end
    run_op(1'b1, 3'd0, 32'h80000013, 32'h000000A5);
    tests++;
    if ({o_mask, o_wdata} !== {4'h8, 32'hA5A5A5A5}) begin
      fails++;
      $display("FAIL sb: got m=%h d=%h want 8 a5a5a5a5", o_mask, o_wdata);
    end
    run_op(1'b0, 3'd0, 32'h80000013, 32'h0);
    tests++;
    if (o_data !== 32'hFFFFFFA5) begin
      fails++;
      $display("FAIL lb: got %h want ffffffa5", o_data);
    end
    run_op(1'b0, 3'd4, 32'h80000013, 32'h0);
    tests++;
    if (o_data !== 32'h000000A5) begin
      fails++;
      $display("FAIL lbu: got %h want 000000a5", o_data);
    end
    run_op(1'b1, 3'd1, 32'h80000022, 32'h00008001);
    tests++;
    if (o_mask !== 4'hC) begin
      fails++;
      $display("FAIL sh: got m=%h want c", o_mask);
    end
    run_op(1'b0, 3'd1, 32'h80000022, 32'h0);
    tests++;
    if (o_data !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL lh: got %h want ffff8001", o_data);
    end
    run_op(1'b0, 3'd5, 32'h80000022, 32'h0);
    tests++;
    if (o_data !== 32'h00008001) begin
      fails++;
      $display("FAIL lhu: got %h want 00008001", o_data);
    end
  endtask

  task automatic test_misalign();
    run_op(1'b0, 3'd2, 32'h80000002, 32'h0);
    tests++;
    if ({o_valid, o_rvalid, o_err, o_data} !== {1'b0, 1'b1, 1'b1, 32'h0}) begin
      fails++;
      $display("FAIL misalign_err: got v=%b rv=%b e=%b d=%h want 0 1 1 0",
               o_valid, o_rvalid, o_err, o_data);
    end
    tests++;
    if ({q_valid, q_addr, q_err, q_data} !==
        {1'b1, 32'h80000000, 1'b0, 32'hCAFEF00D}) begin
      fails++;
      $display("FAIL misalign_snap: got v=%b a=%h e=%b d=%h want 1 80000000 0 cafef00d",
               q_valid, q_addr, q_err, q_data);
    end
    run_op(1'b0, 3'd3, 32'h80000000, 32'h0);
    tests++;
    if ({o_valid, o_err, q_err} !== 3'b011) begin
      fails++;
      $display("FAIL illegal_f3: got v=%b e=%b e1=%b want 0 1 1", o_valid, o_err, q_err);
    end
    run_op(1'b1, 3'd4, 32'h80000000, 32'h0);
    tests++;
    if ({o_valid, o_err} !== 2'b01) begin
      fails++;
      $display("FAIL illegal_sbu: got v=%b e=%b want 0 1", o_valid, o_err);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] e1, e2;
    e1 = m_load(3'd2, 32'h80000010);
    e2 = m_load(3'd5, 32'h80000022);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2;
    req_addr = 32'h80000010; resp_ready = 1'b0;
    @(negedge clk);
    req_funct3 = 3'd5; req_addr = 32'h80000022;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if ({resp_valid, resp_rdata, req_ready} !== {1'b1, e1, 1'b0}) begin
        fails++;
        $display("FAIL stall_%0d: got v=%b d=%h rdy=%b want 1 %h 0",
                 i, resp_valid, resp_rdata, req_ready, e1);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 1'b0) begin
      fails++;
      $display("FAIL no_bypass: got rdy=%b want 0", req_ready);
    end
    @(negedge clk);
    tests++;
    if ({req_ready, resp_valid} !== 2'b10) begin
      fails++;
      $display("FAIL back_idle: got rdy=%b v=%b want 1 0", req_ready, resp_valid);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if ({valid, dmem_addr} !== {1'b1, 32'h80000020}) begin
      fails++;
      $display("FAIL held_req: got v=%b a=%h want 1 80000020", valid, dmem_addr);
    end
    @(negedge clk);
    tests++;
    if (resp_rdata !== e2) begin
      fails++;
      $display("FAIL held_data: got %h want %h", resp_rdata, e2);
    end
  endtask

  task automatic test_reset_access();
    logic [31:0] e;
    e = m_load(3'd2, 32'h80000040);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h80000040; req_wdata = ~e; resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({valid, dmem_wen} !== 2'b00) begin
      fails++;
      $display("FAIL rst_access: got v=%b wen=%b want 0 0", valid, dmem_wen);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if ({req_ready, valid, dmem_wmask, dmem_addr, resp_valid, resp_err, resp_rdata}
        !== {1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL rst_after: got rdy=%b v=%b m=%h a=%h rv=%b e=%b d=%h want reset values",
               req_ready, valid, dmem_wmask, dmem_addr, resp_valid, resp_err, resp_rdata);
    end
    run_op(1'b0, 3'd2, 32'h80000040, 32'h0);
    tests++;
    if (o_data !== e) begin
      fails++;
      $display("FAIL rst_nowrite: got %h want %h", o_data, e);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic        w, ee;
    logic [2:0]  f;
    logic [31:0] a, d, ed;
    for (int k = 0; k < 300; k++) begin
      w = 1'($urandom % 2);
      f = ($urandom % 6 == 0) ? 3'($urandom) : f3s[$urandom % 5];
      a = 32'h80000000 | 32'($urandom_range(0, 255));
      d = $urandom;
      ee = m_err(w, f, a);
      ed = (ee || w) ? 32'h0 : m_load(f, a);
      run_op(w, f, a, d);
      tests++;
      if ({o_rvalid, o_err, o_data, o_valid} !== {1'b1, ee, ed, !ee}) begin
        fails++;
        $display("FAIL rand_%0d w=%b f=%0d a=%h: got rv=%b e=%b d=%h v=%b want 1 %b %h %b",
                 k, w, f, a, o_rvalid, o_err, o_data, o_valid, ee, ed, !ee);
      end
      if (w && !ee) begin
        tests++;
        if ({o_wen, o_mask, o_addr, o_wdata} !==
            {1'b1, m_mask(f, a), {a[31:2], 2'b00}, m_wdata(f, d)}) begin
          fails++;
          $display("FAIL rand_st_%0d: got wen=%b m=%h a=%h d=%h want 1 %h %h %h",
                   k, o_wen, o_mask, o_addr, o_wdata,
                   m_mask(f, a), {a[31:2], 2'b00}, m_wdata(f, d));
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = 8'($urandom);
    for (int i = 0; i < 64; i++)
      ram[i] = {mdl[4*i+3], mdl[4*i+2], mdl[4*i+1], mdl[4*i]};
    test_reset();
    test_directed();
    test_misalign();
    test_backpressure();
    test_reset_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
